// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
//   Parametrised two-read / one-write CPU register file with:
//     - optional hard-wired zero register (ZERO_REG)
//     - optional write-to-read bypass (BYPASS)
//     - per-register pending scoreboard for load-use detection
//     - a DEPTH-cycle sequenced CLEAR that wipes the file without RESET
//
// Ports
//   CLOCK        in   system clock, rising edge
//   RESET        in   asynchronous active-high reset
//   OUT1ADDRESS  in   read port 1 address
//   OUT2ADDRESS  in   read port 2 address
//   INADDRESS    in   write address
//   IN           in   write data
//   WRITE        in   write enable
//   BUSYWAIT     in   memory stall; blocks writes and pending-set
//   CLEAR        in   start the sequenced clear
//   PEND_SET     in   mark PEND_ADDR as awaiting a result
//   PEND_ADDR    in   register to mark pending
//   OUT1/OUT2    out  read data
//   OUT1_PEND    out  pending bit of OUT1ADDRESS
//   OUT2_PEND    out  pending bit of OUT2ADDRESS
//   CLR_BUSY     out  high while the clear sequence runs
// ---------------------------------------------------------------------------
module reg_file_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int ZERO_REG   = 0,
    parameter int BYPASS     = 0
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
    input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
    input  logic [ADDR_WIDTH-1:0] INADDRESS,
    input  logic [DATA_WIDTH-1:0] IN,
    input  logic                  WRITE,
    input  logic                  BUSYWAIT,
    input  logic                  CLEAR,
    input  logic                  PEND_SET,
    input  logic [ADDR_WIDTH-1:0] PEND_ADDR,
    output logic [DATA_WIDTH-1:0] OUT1,
    output logic [DATA_WIDTH-1:0] OUT2,
    output logic                  OUT1_PEND,
    output logic                  OUT2_PEND,
    output logic                  CLR_BUSY
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_CLEARING = 1'b1
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_clr_idx;
    logic                    r_clr_busy;
    logic [DATA_WIDTH-1:0]   r_regs [DEPTH];
    logic [DEPTH-1:0]        r_pend;

    logic                    w_idle;
    logic                    w_commit;
    logic                    w_pend_set;

    assign w_idle = (r_state == ST_IDLE);

    // RESET is folded in so the bypass path cannot forward IN while the
    // file is being held in reset.
    assign w_commit = WRITE && !BUSYWAIT && w_idle && !RESET &&
                      !((ZERO_REG != 0) && (INADDRESS == '0));

    assign w_pend_set = PEND_SET && !BUSYWAIT && w_idle &&
                        !((ZERO_REG != 0) && (PEND_ADDR == '0));

    // -----------------------------------------------------------------------
    // Clear sequencer. Termination compares against the last index rather
    // than waiting for the counter to wrap, so duration is exactly DEPTH.
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_clr_idx  <= '0;
            r_clr_busy <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (CLEAR) begin
                        r_state    <= ST_CLEARING;
                        r_clr_idx  <= '0;
                        r_clr_busy <= 1'b1;
                    end
                end
                ST_CLEARING: begin
                    r_clr_idx <= r_clr_idx + 1'b1;
                    if (r_clr_idx == LAST_IDX) begin
                        r_state    <= ST_IDLE;
                        r_clr_busy <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_clr_busy <= 1'b0;
                end
            endcase
        end
    end

    assign CLR_BUSY = r_clr_busy;

    // -----------------------------------------------------------------------
    // Register array and pending scoreboard.
    // -----------------------------------------------------------------------
    // NOTE: the array must read as zero during RESET, so it is built from
    // resettable flops rather than an inferred RAM macro.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_pend <= '0;
        end else if (r_state == ST_CLEARING) begin
            // WRITE, PEND_SET and CLEAR are deliberately dropped here.
            r_regs[r_clr_idx] <= '0;
            r_pend[r_clr_idx] <= 1'b0;
        end else begin
            if (w_commit) begin
                r_regs[INADDRESS] <= IN;
                r_pend[INADDRESS] <= 1'b0;
            end
            // Placed after the commit so a same-address set wins.
            if (w_pend_set) begin
                r_pend[PEND_ADDR] <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read ports
    // -----------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        OUT1      = r_regs[OUT1ADDRESS];
        OUT1_PEND = r_pend[OUT1ADDRESS];
        OUT2      = r_regs[OUT2ADDRESS];
        OUT2_PEND = r_pend[OUT2ADDRESS];

        if ((ZERO_REG != 0) && (OUT1ADDRESS == '0)) begin
            OUT1      = '0;
            OUT1_PEND = 1'b0;
        end
        if ((ZERO_REG != 0) && (OUT2ADDRESS == '0)) begin
            OUT2      = '0;
            OUT2_PEND = 1'b0;
        end

        // w_commit already excludes the zero register, so the bypass can
        // never override the hard-wired zero above.
        if ((BYPASS != 0) && w_commit && (INADDRESS == OUT1ADDRESS)) begin
            OUT1      = IN;
            OUT1_PEND = 1'b0;
        end
        if ((BYPASS != 0) && w_commit && (INADDRESS == OUT2ADDRESS)) begin
            OUT2      = IN;
            OUT2_PEND = 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// ---------------------------------------------------------------------------
// tb_reg_file_param
//   Directed bench for reg_file_param. Two instances share all inputs:
//     u_dut    : default parameters (no zero register, no bypass)
//     u_dut_zb : ZERO_REG=1, BYPASS=1
//   Inputs change 1 time unit after a rising edge; outputs are sampled a
//   further 1 unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_reg_file_param;

    logic       CLOCK;
    logic       RESET;
    logic [2:0] OUT1ADDRESS, OUT2ADDRESS, INADDRESS, PEND_ADDR;
    logic [7:0] IN;
    logic       WRITE, BUSYWAIT, CLEAR, PEND_SET;

    logic [7:0] o1, o2, z_o1, z_o2;
    logic       p1, p2, z_p1, z_p2, busy, z_busy;

    int n_checks = 0;
    int n_errors = 0;

    reg_file_param u_dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .OUT1ADDRESS(OUT1ADDRESS),
        .OUT2ADDRESS(OUT2ADDRESS),
        .INADDRESS  (INADDRESS),
        .IN         (IN),
        .WRITE      (WRITE),
        .BUSYWAIT   (BUSYWAIT),
        .CLEAR      (CLEAR),
        .PEND_SET   (PEND_SET),
        .PEND_ADDR  (PEND_ADDR),
        .OUT1       (o1),
        .OUT2       (o2),
        .OUT1_PEND  (p1),
        .OUT2_PEND  (p2),
        .CLR_BUSY   (busy)
    );

    reg_file_param #(.ZERO_REG(1), .BYPASS(1)) u_dut_zb (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .OUT1ADDRESS(OUT1ADDRESS),
        .OUT2ADDRESS(OUT2ADDRESS),
        .INADDRESS  (INADDRESS),
        .IN         (IN),
        .WRITE      (WRITE),
        .BUSYWAIT   (BUSYWAIT),
        .CLEAR      (CLEAR),
        .PEND_SET   (PEND_SET),
        .PEND_ADDR  (PEND_ADDR),
        .OUT1       (z_o1),
        .OUT2       (z_o2),
        .OUT1_PEND  (z_p1),
        .OUT2_PEND  (z_p2),
        .CLR_BUSY   (z_busy)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    initial begin
        RESET       = 1'b1;
        OUT1ADDRESS = 3'd3;
        OUT2ADDRESS = 3'd0;
        INADDRESS   = 3'd0;
        PEND_ADDR   = 3'd0;
        IN          = 8'h00;
        WRITE       = 1'b0;
        BUSYWAIT    = 1'b0;
        CLEAR       = 1'b0;
        PEND_SET    = 1'b0;

        // ---- reset state -------------------------------------------------
        #3;
        check("rst_out1", o1, 8'h00);
        check("rst_pend1", p1, 1'b0);
        check("rst_busy", busy, 1'b0);
        #10 RESET = 1'b0;

        // ---- 1: write r3, then async reset mid-cycle ----------------------
        tick();
        WRITE = 1'b1; INADDRESS = 3'd3; IN = 8'h5A;
        #1 check("t1_nobyp_pre", o1, 8'h00);
        tick();
        WRITE = 1'b0;
        #1 check("t1_r3_after", o1, 8'h5A);
        RESET = 1'b1;
        #1 check("t1_async_rst_out1", o1, 8'h00);
        check("t1_async_rst_zb", z_o1, 8'h00);
        RESET = 1'b0;
        tick();
        WRITE = 1'b1; INADDRESS = 3'd3; IN = 8'h5A;
        tick();
        WRITE = 1'b0;
        #1 check("t1_r3_rewrite", o1, 8'h5A);
        check("t1_r3_rewrite_zb", z_o1, 8'h5A);

        // ---- 2: BUSYWAIT blocks the commit --------------------------------
        OUT1ADDRESS = 3'd2;
        WRITE = 1'b1; INADDRESS = 3'd2; IN = 8'h33; BUSYWAIT = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_stalled", o1, 8'h00);
            check("t2_stalled_nobyp_zb", z_o1, 8'h00);
        end
        BUSYWAIT = 1'b0;
        #1 check("t2_byp_released", z_o1, 8'h33);
        check("t2_pre_edge", o1, 8'h00);
        tick();
        WRITE = 1'b0;
        #1 check("t2_committed", o1, 8'h33);

        // ---- 3: bypass vs. no bypass --------------------------------------
        OUT2ADDRESS = 3'd5;
        WRITE = 1'b1; INADDRESS = 3'd5; IN = 8'h77;
        #1 check("t3_bypass_pre", z_o2, 8'h77);
        check("t3_nobyp_pre", o2, 8'h00);
        tick();
        WRITE = 1'b0;
        #1 check("t3_nobyp_post", o2, 8'h77);

        // ---- 4: zero register ---------------------------------------------
        OUT1ADDRESS = 3'd0;
        WRITE = 1'b1; INADDRESS = 3'd0; IN = 8'hFF;
        PEND_SET = 1'b1; PEND_ADDR = 3'd0;
        #1 check("t4_zero_pre", z_o1, 8'h00);
        tick();
        WRITE = 1'b0; PEND_SET = 1'b0;
        #1 check("t4_zero_data", z_o1, 8'h00);
        check("t4_zero_pend", z_p1, 1'b0);
        check("t4_plain_r0_data", o1, 8'hFF);
        check("t4_plain_r0_pend", p1, 1'b1);

        // ---- 5: pending scoreboard ----------------------------------------
        OUT1ADDRESS = 3'd4;
        PEND_SET = 1'b1; PEND_ADDR = 3'd4;
        tick();
        PEND_SET = 1'b0;
        #1 check("t5_pend_set", p1, 1'b1);
        check("t5_pend_set_zb", z_p1, 1'b1);
        WRITE = 1'b1; INADDRESS = 3'd4; IN = 8'h44;
        #1 check("t5_byp_pend_clr", z_p1, 1'b0);
        check("t5_pend_pre_commit", p1, 1'b1);
        tick();
        WRITE = 1'b0;
        #1 check("t5_pend_cleared", p1, 1'b0);
        check("t5_data", o1, 8'h44);
        WRITE = 1'b1; INADDRESS = 3'd4; IN = 8'h4C;
        PEND_SET = 1'b1; PEND_ADDR = 3'd4;
        tick();
        WRITE = 1'b0; PEND_SET = 1'b0;
        #1 check("t5_set_wins_pend", p1, 1'b1);
        check("t5_set_wins_data", o1, 8'h4C);
        check("t5_set_wins_zb", z_p1, 1'b1);

        // ---- 6: sequenced clear -------------------------------------------
        for (int i = 0; i < 8; i++) begin
            WRITE = 1'b1; INADDRESS = 3'(i); IN = 8'((i + 1) * 8'h11);
            tick();
        end
        WRITE = 1'b0;
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        for (int k = 0; k < 8; k++) begin
            OUT1ADDRESS = 3'(k);
            if (k == 3) begin
                // Dropped: r0 is already cleared and must stay zero.
                WRITE = 1'b1; INADDRESS = 3'd0; IN = 8'hEE;
            end
            #1 check($sformatf("t6_busy_c%0d", k), busy, 1'b1);
            check($sformatf("t6_before_c%0d", k), o1, 8'((k + 1) * 8'h11));
            tick();
            WRITE = 1'b0;
            #1 check($sformatf("t6_zeroed_c%0d", k), o1, 8'h00);
        end
        check("t6_busy_done", busy, 1'b0);
        check("t6_busy_done_zb", z_busy, 1'b0);
        OUT1ADDRESS = 3'd0;
        #1 check("t6_write_dropped", o1, 8'h00);

        // ---- 6b: RESET during clear cycle 3 -------------------------------
        WRITE = 1'b1; INADDRESS = 3'd5; IN = 8'h55;
        tick();
        INADDRESS = 3'd7; IN = 8'h78;
        tick();
        WRITE = 1'b0;
        OUT1ADDRESS = 3'd5; OUT2ADDRESS = 3'd7;
        #1 check("t6b_r5_loaded", o1, 8'h55);
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        tick(); tick(); tick();
        check("t6b_busy_c3", busy, 1'b1);
        RESET = 1'b1;
        #1 check("t6b_rst_busy", busy, 1'b0);
        check("t6b_rst_r5", o1, 8'h00);
        check("t6b_rst_r7", o2, 8'h00);
        RESET = 1'b0;
        tick();
        check("t6b_not_resumed", busy, 1'b0);
        WRITE = 1'b1; INADDRESS = 3'd6; IN = 8'h99; OUT1ADDRESS = 3'd6;
        tick();
        WRITE = 1'b0;
        #1 check("t6b_write_after", o1, 8'h99);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #20000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
